// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file arbiter: FSM states, latched command and the
// round-robin grant helper used by rr_arb2.
package regfile_arb_pkg;

    localparam int RF_DW = 16;
    localparam int RF_AW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic             id;
        logic             we;
        logic [RF_AW-1:0] aa;
        logic [RF_AW-1:0] ba;
        logic [RF_AW-1:0] da;
        logic [RF_DW-1:0] dd;
    } rf_cmd_t;

    // With both requesters eligible the one that did not win last time is chosen.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic last_grant);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last_grant register; the optional grant lock is
// compiled in with RFARB_LOCK_EN.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    logic       last_grant_reg;
    logic [1:0] eligible;
    logic       accept;
    logic       gnt_id;

    // A grant is only offered to a valid requester, so any grant is a handshake.
    assign accept = |gnt;
    assign gnt_id = gnt[1];

`ifdef RFARB_LOCK_EN
    logic lock_held_reg;
    logic lock_owner_reg;

    always_comb begin
        eligible = req;
        if (lock_held_reg) begin
            eligible = lock_owner_reg ? (req & 2'b10) : (req & 2'b01);
        end
    end

    // While held only the owner can be granted, so a lock=0 handshake always releases.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_held_reg  <= 1'b0;
            lock_owner_reg <= 1'b0;
        end else if (accept) begin
            if (lock[gnt_id]) begin
                lock_held_reg  <= 1'b1;
                lock_owner_reg <= gnt_id;
            end else begin
                lock_held_reg  <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign eligible    = req;
`endif

    always_comb begin
        gnt = rr_grant(eligible, last_grant_reg);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one 8x16 register file between two requesters, one command in flight at a time.
// Define RFARB_LOCK_EN to let a requester hold the grant across commands.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_aa,
    input  logic [AW-1:0] req0_ba,
    input  logic [AW-1:0] req0_da,
    input  logic [DW-1:0] req0_dd,
    input  logic          req0_lock,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_aa,
    input  logic [AW-1:0] req1_ba,
    input  logic [AW-1:0] req1_da,
    input  logic [DW-1:0] req1_dd,
    input  logic          req1_lock,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp_ad,
    output logic [DW-1:0] rsp_bd,
    output logic [AW-1:0] AA,
    output logic [AW-1:0] BA,
    output logic [AW-1:0] DA,
    output logic [DW-1:0] DD,
    output logic          RW,
    input  logic [DW-1:0] AD,
    input  logic [DW-1:0] BD
);

    state_t        state_reg, state_next;
    rf_cmd_t       cmd_reg, cmd_next;
    logic [DW-1:0] rsp_ad_reg, rsp_bd_reg;
    logic [1:0]    arb_req;
    logic [1:0]    arb_gnt;
    logic [1:0]    rsp_ready_vec;
    logic [1:0]    rsp_valid_vec;
    logic          accept;
    logic          rsp_done;

    // Requests are only visible to the arbiter while idle, so ready drops in ISSUE/RESP.
    assign arb_req = (state_reg == IDLE) ? {req1_valid, req0_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (arb_req),
        .lock  ({req1_lock, req0_lock}),
        .gnt   (arb_gnt)
    );

    assign req0_ready = arb_gnt[0];
    assign req1_ready = arb_gnt[1];
    assign accept     = |arb_gnt;

    always_comb begin
        cmd_next = cmd_reg;
        if (accept) begin
            if (arb_gnt[1]) begin
                cmd_next = '{id: 1'b1, we: req1_we, aa: req1_aa, ba: req1_ba,
                             da: req1_da, dd: req1_dd};
            end else begin
                cmd_next = '{id: 1'b0, we: req0_we, aa: req0_aa, ba: req0_ba,
                             da: req0_da, dd: req0_dd};
            end
        end
    end

    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid_vec[gi] = (state_reg == RESP) && (cmd_reg.id == 1'(gi));
    end

    assign rsp_done = rsp_valid_vec[cmd_reg.id] && rsp_ready_vec[cmd_reg.id];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)   state_next = ISSUE;
            ISSUE:                 state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            cmd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
        end
    end

    // Read data is sampled at the edge that performs the write, hence pre-write values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_ad_reg <= '0;
            rsp_bd_reg <= '0;
        end else if (state_reg == ISSUE) begin
            rsp_ad_reg <= AD;
            rsp_bd_reg <= BD;
        end
    end

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp_ad     = rsp_ad_reg;
    assign rsp_bd     = rsp_bd_reg;

    // Addresses follow the command register, which only changes on a handshake.
    assign AA = cmd_reg.aa;
    assign BA = cmd_reg.ba;
    assign DA = cmd_reg.da;
    assign DD = cmd_reg.dd;
    assign RW = (state_reg == ISSUE) && cmd_reg.we;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: a command-level model with its own register
// file contents, directed scenarios plus randomized traffic.
module tb_regfile_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req0_valid = 0, req0_we = 0, req0_lock = 0;
    logic        req1_valid = 0, req1_we = 0, req1_lock = 0;
    logic [2:0]  req0_aa = 0, req0_ba = 0, req0_da = 0;
    logic [2:0]  req1_aa = 0, req1_ba = 0, req1_da = 0;
    logic [15:0] req0_dd = 0, req1_dd = 0;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, RW;
    logic [15:0] rsp_ad, rsp_bd, DD, AD, BD;
    logic [2:0]  AA, BA, DA;

    always #5 CLK = ~CLK;

    regfile_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_aa(req0_aa), .req0_ba(req0_ba), .req0_da(req0_da), .req0_dd(req0_dd),
        .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_aa(req1_aa), .req1_ba(req1_ba), .req1_da(req1_da), .req1_dd(req1_dd),
        .req1_lock(req1_lock),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_ad(rsp_ad), .rsp_bd(rsp_bd),
        .AA(AA), .BA(BA), .DA(DA), .DD(DD), .RW(RW), .AD(AD), .BD(BD)
    );

    // Physical register file driven by the DUT pins, cleared by the same reset.
    logic [15:0] rf [8];
    assign AD = rf[AA];
    assign BD = rf[BA];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
        end else if (RW) begin
            rf[DA] <= DD;
        end
    end

    // Command-level model: in-flight command, its age in cycles, and golden contents.
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          m_busy;
    int          m_age;
    int          m_id;
    bit          m_we;
    logic [2:0]  m_aa, m_ba, m_da;
    logic [15:0] m_dd, m_ad, m_bd;
    int          m_last;
    bit          m_lock_held;
    int          m_lock_owner;
    logic [15:0] gold [8];
    int          grant_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_age = 0; m_id = 0; m_we = 0;
        m_aa = 0; m_ba = 0; m_da = 0; m_dd = 0; m_ad = 0; m_bd = 0;
        m_last = 1; m_lock_held = 0; m_lock_owner = 0;
        for (int i = 0; i < 8; i++) gold[i] = 16'h0;
    endfunction

    function automatic int m_pick();
        bit v0 = req0_valid;
        bit v1 = req1_valid;
`ifdef RFARB_LOCK_EN
        if (m_lock_held) begin
            if (m_lock_owner == 0) v1 = 0;
            else v0 = 0;
        end
`endif
        if (v0 && v1) return (m_last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic settle();
        int w;
        bit in_resp;
        #1;
        w = m_busy ? -1 : m_pick();
        in_resp = m_busy && (m_age == 2);
        chk("ready0", req0_ready, w == 0);
        chk("ready1", req1_ready, w == 1);
        chk("rw", RW, m_busy && m_age == 1 && m_we);
        chk("rsp0_valid", rsp0_valid, in_resp && m_id == 0);
        chk("rsp1_valid", rsp1_valid, in_resp && m_id == 1);
        chk("aa", AA, m_aa);
        chk("ba", BA, m_ba);
        chk("da", DA, m_da);
        chk("dd", DD, m_dd);
        if (in_resp) begin
            chk("rsp_ad", rsp_ad, m_ad);
            chk("rsp_bd", rsp_bd, m_bd);
        end
    endtask

    task automatic advance();
        int  w;
        bit  lk;
        if (!m_busy) begin
            w = m_pick();
            if (w >= 0) begin
                m_id = w;
                if (w == 0) begin
                    m_we = req0_we; m_aa = req0_aa; m_ba = req0_ba; m_da = req0_da;
                    m_dd = req0_dd; lk = req0_lock;
                end else begin
                    m_we = req1_we; m_aa = req1_aa; m_ba = req1_ba; m_da = req1_da;
                    m_dd = req1_dd; lk = req1_lock;
                end
                m_ad = gold[m_aa];
                m_bd = gold[m_ba];
                if (m_we) gold[m_da] = m_dd;
                m_last = w;
`ifdef RFARB_LOCK_EN
                m_lock_held  = lk;
                if (lk) m_lock_owner = w;
`else
                lk = 0;
`endif
                grant_q.push_back(w);
                m_busy = 1;
                m_age  = 1;
                $display("[TB] grant req%0d we=%0d aa=%0d ba=%0d da=%0d dd=%h lock=%0d exp_ad=%h exp_bd=%h",
                         w, m_we, m_aa, m_ba, m_da, m_dd, lk, m_ad, m_bd);
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if ((m_id == 0) ? rsp0_ready : rsp1_ready) begin
            m_busy = 0;
        end
        @(negedge CLK);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic drain(input string name);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 10 && m_busy; i++) cycle();
        if (m_busy) chk({name, "_drain_timeout"}, 0, 1);
    endtask

    task automatic run_until_grant(input string name);
        int start = grant_q.size();
        for (int i = 0; i < 20 && grant_q.size() == start; i++) cycle();
        if (grant_q.size() == start) chk({name, "_grant_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n1;
        logic [15:0] held_ad;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 0;

        // Reset state.
        settle();
        chk("rst_rw", RW, 0);
        chk("rst_rsp_ad", rsp_ad, 0);
        chk("rst_aa", AA, 0);
        chk("rst_dd", DD, 0);
        advance();

        // req0 writes R3 = 1234: ready, then RW/DA/DD, then response.
        req0_valid = 1; req0_we = 1; req0_da = 3; req0_dd = 16'h1234; req0_aa = 0; req0_ba = 0;
        rsp0_ready = 1;
        settle(); chk("wr_ready0", req0_ready, 1); advance();
        req0_valid = 0;
        settle(); chk("wr_rw", RW, 1); chk("wr_da", DA, 3); chk("wr_dd", DD, 16'h1234); advance();
        settle(); chk("wr_rsp0_valid", rsp0_valid, 1); advance();
        cycle();

        // req1 reads R3 and R0.
        req1_valid = 1; req1_we = 0; req1_aa = 3; req1_ba = 0; rsp1_ready = 1;
        settle(); chk("rd_ready1", req1_ready, 1); advance();
        req1_valid = 0;
        settle(); chk("rd_rw", RW, 0); advance();
        settle();
        chk("rd_rsp1_valid", rsp1_valid, 1); chk("rd_ad", rsp_ad, 16'h1234);
        chk("rd_bd", rsp_bd, 16'h0000); chk("rd_rw2", RW, 0);
        advance();
        cycle();

        // Both valid continuously: grants alternate starting with req0.
        grant_q.delete();
        req0_we = 0; req1_we = 0; rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 40 && grant_q.size() < 6; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_aa = 3'($urandom); req0_ba = 3'($urandom);
            req1_aa = 3'($urandom); req1_ba = 3'($urandom);
            cycle();
        end
        drain("rr");
        chk("rr_count", (grant_q.size() >= 6), 1);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) chk($sformatf("rr_grant%0d", i), grant_q[i], i % 2);

        // Response stall: rsp0_ready low for 5 cycles, req1 waiting.
        req0_valid = 1; req0_we = 0; req0_aa = 3; req0_ba = 1; rsp0_ready = 0;
        run_until_grant("stall");
        req0_valid = 0; req1_valid = 1; req1_we = 0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_rsp0_valid", rsp0_valid, 1);
            chk("stall_ad", rsp_ad, 16'h1234);
            chk("stall_ready1", req1_ready, 0);
            advance();
        end
        rsp0_ready = 1;
        cycle();
        settle(); chk("stall_resume_ready1", req1_ready, 1); advance();
        drain("stall");

        // Reset during the ISSUE cycle of a write.
        req0_valid = 1; req0_we = 1; req0_da = 5; req0_dd = 16'hABCD;
        run_until_grant("rstmid");
        req0_valid = 0;
        settle(); chk("rstmid_rw_before", RW, 1);
        RESET = 1;
        #1;
        chk("rstmid_rw", RW, 0);
        chk("rstmid_rsp0", rsp0_valid, 0);
        model_reset();
        @(negedge CLK); @(negedge CLK);
        RESET = 0;
        req0_valid = 1; req1_valid = 1; req0_we = 0; req1_we = 0; req0_aa = 5; req0_ba = 3;
        settle(); chk("rstmid_gnt0", req0_ready, 1); chk("rstmid_gnt1", req1_ready, 0); advance();
        req0_valid = 0; req1_valid = 0;
        cycle();
        settle(); chk("rstmid_cleared", rsp_ad, 0); advance();
        drain("rstmid");

        // Lock sequence: req1 lock=1 then lock=0 while req0 stays valid.
        req0_valid = 1; req0_we = 0;
        run_until_grant("lock_pre");
        drain("lock_pre");
        grant_q.delete();
        for (int i = 0; i < 60 && grant_q.size() < 3; i++) begin
            n1 = 0;
            foreach (grant_q[k]) if (grant_q[k] == 1) n1++;
            req0_valid = 1; req1_valid = 1; req1_lock = (n1 == 0);
            cycle();
        end
        req1_lock = 0;
        drain("lock");
        chk("lock_count", (grant_q.size() >= 3), 1);
        if (grant_q.size() >= 3) begin
            chk("lock_g0", grant_q[0], 1);
`ifdef RFARB_LOCK_EN
            chk("lock_g1", grant_q[1], 1);
            chk("lock_g2", grant_q[2], 0);
`else
            chk("lock_g1", grant_q[1], 0);
            chk("lock_g2", grant_q[2], 1);
`endif
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_we = 1'($urandom); req1_we = 1'($urandom);
            req0_aa = 3'($urandom); req0_ba = 3'($urandom); req0_da = 3'($urandom);
            req1_aa = 3'($urandom); req1_ba = 3'($urandom); req1_da = 3'($urandom);
            req0_dd = 16'($urandom); req1_dd = 16'($urandom);
            req0_lock = ($urandom_range(0, 3) == 0);
            req1_lock = ($urandom_range(0, 3) == 0);
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        req0_lock = 0; req1_lock = 0;
        drain("rand");
        held_ad = rf[3];
        chk("final_rf3", held_ad, gold[3]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
